// File: rtl/program_loader_if.sv
// program_loader_if
//   Bundles the loader's command, stream and memory-write signals.
//   Signal names are written from the loader's point of view:
//     i_* : driven by the environment (command + source stream)
//     o_* : driven by the loader (ready, memory write port, status)
//   Modports:
//     slave  : the loader itself
//     master : the environment (source, controller, memory/CPU side)
interface program_loader_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16
);
  // command
  logic                   i_start;
  logic [ADDR_WIDTH-1:0]  i_base_addr;
  logic [ADDR_WIDTH-1:0]  i_word_count;
  logic [INSTR_WIDTH-1:0] i_expected_sum;
  // source stream
  logic                   i_s_valid;
  logic [INSTR_WIDTH-1:0] i_s_data;
  logic                   o_s_ready;
  // instruction memory write port
  logic                   o_mem_we;
  logic [ADDR_WIDTH-1:0]  o_mem_addr;
  logic [INSTR_WIDTH-1:0] o_mem_wdata;
  // CPU hold and status
  logic                   o_cpu_reset;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_error;
  logic [ADDR_WIDTH-1:0]  o_words_loaded;

  modport slave (
    input  i_start, i_base_addr, i_word_count, i_expected_sum,
    input  i_s_valid, i_s_data,
    output o_s_ready,
    output o_mem_we, o_mem_addr, o_mem_wdata,
    output o_cpu_reset, o_busy, o_done, o_error, o_words_loaded
  );

  modport master (
    output i_start, i_base_addr, i_word_count, i_expected_sum,
    output i_s_valid, i_s_data,
    input  o_s_ready,
    input  o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_cpu_reset, o_busy, o_done, o_error, o_words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Streams an instruction image from a valid/ready source into CPU
//   instruction memory, holding the CPU in reset until the whole image has
//   been written and (when CHECK_EN != 0) its additive checksum matches.
// Ports:
//   i_clk    : system clock, rising edge
//   i_reset  : asynchronous, active-high reset
//   bus      : program_loader_if.slave
//     i_start/i_base_addr/i_word_count/i_expected_sum : load command
//     i_s_valid/i_s_data/o_s_ready                    : source stream
//     o_mem_we/o_mem_addr/o_mem_wdata                 : memory write port
//     o_cpu_reset/o_busy/o_done/o_error/o_words_loaded: status
module program_loader #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int CHECK_EN    = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  program_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [ADDR_WIDTH-1:0]  r_count;
  logic [INSTR_WIDTH-1:0] r_exp_sum;
  logic [INSTR_WIDTH-1:0] r_sum;
  logic [ADDR_WIDTH-1:0]  r_words;
  logic                   r_s_ready;
  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [INSTR_WIDTH-1:0] r_mem_wdata;
  logic                   r_cpu_reset;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic                   w_beat;
  logic                   w_last;

  // r_s_ready is high exactly while in LOAD, so a beat never depends on
  // anything but the state and the source's valid.
  assign w_beat = bus.i_s_valid & r_s_ready;
  // Beat being accepted now is the final word of the image.
  assign w_last = (r_words == (r_count - {{(ADDR_WIDTH-1){1'b0}}, 1'b1}));

  // Load sequencer: state, captured command, counters and all outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_base      <= {ADDR_WIDTH{1'b0}};
      r_count     <= {ADDR_WIDTH{1'b0}};
      r_exp_sum   <= {INSTR_WIDTH{1'b0}};
      r_sum       <= {INSTR_WIDTH{1'b0}};
      r_words     <= {ADDR_WIDTH{1'b0}};
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_WIDTH{1'b0}};
      r_mem_wdata <= {INSTR_WIDTH{1'b0}};
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // write strobe is a one-cycle pulse following each beat
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (bus.i_start) begin
            r_base      <= bus.i_base_addr;
            r_count     <= bus.i_word_count;
            r_exp_sum   <= bus.i_expected_sum;
            r_sum       <= {INSTR_WIDTH{1'b0}};
            r_words     <= {ADDR_WIDTH{1'b0}};
            r_done      <= 1'b0;
            // CPU is re-held on the same edge that leaves RUN
            r_cpu_reset <= 1'b1;
            if (bus.i_word_count == {ADDR_WIDTH{1'b0}}) begin
              r_state   <= ST_ERROR;
              r_error   <= 1'b1;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
            end else begin
              r_state   <= ST_LOAD;
              r_error   <= 1'b0;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_base + r_words;  // wraps silently
            r_mem_wdata <= bus.i_s_data;
            r_sum       <= r_sum + bus.i_s_data;
            r_words     <= r_words + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (w_last) begin
              r_state   <= ST_CHECK;
              r_s_ready <= 1'b0;
            end else begin
              r_state   <= ST_LOAD;
            end
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_CHECK: begin
          // r_sum already includes the final word accepted on entry
          r_busy <= 1'b0;
          if ((CHECK_EN == 0) || (r_sum == r_exp_sum)) begin
            r_state     <= ST_RUN;
            r_cpu_reset <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_state     <= ST_ERROR;
            r_error     <= 1'b1;
          end
        end
        default: begin
          // unreachable encoding: fall back to a safe, CPU-held idle
          r_state     <= ST_IDLE;
          r_s_ready   <= 1'b0;
          r_cpu_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_s_ready      = r_s_ready;
  assign bus.o_mem_we       = r_mem_we;
  assign bus.o_mem_addr     = r_mem_addr;
  assign bus.o_mem_wdata    = r_mem_wdata;
  assign bus.o_cpu_reset    = r_cpu_reset;
  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
  assign bus.o_error        = r_error;
  assign bus.o_words_loaded = r_words;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Synthesizable loader that streams an instruction image into CPU instruction memory over a valid/ready interface.
- Drives the memory write port: load enable, address and instruction word.
- Holds the CPU program counter in reset until the full image is written and, optionally, checksum-verified.
- Generalises the fixed 16-bit, fixed-length bench loading flow into a parametrised, handshaked hardware block with integrity checking and reload.

Parameters:
INSTR_WIDTH, 16, width of an instruction word
ADDR_WIDTH, 16, instruction memory address width; also the width of the word count
CHECK_EN, 1, 1 = compare the running checksum with expected_sum before release; 0 = skip the check

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a load
base_addr  in  ADDR_WIDTH  first memory address written; captured on start
word_count  in  ADDR_WIDTH  number of words to load; captured on start
expected_sum  in  INSTR_WIDTH  expected checksum; captured on start
s_valid  in  1  source data valid
s_data  in  INSTR_WIDTH  instruction word
s_ready  out  1  loader accepts a word
mem_we  out  1  instruction memory write enable (CPU load_instruction)
mem_addr  out  ADDR_WIDTH  write address (CPU load_address)
mem_wdata  out  INSTR_WIDTH  write data (CPU instruction_in)
cpu_reset  out  1  active-high hold for the CPU pc_reset
busy  out  1  high in LOAD and CHECK
done  out  1  image accepted; CPU running
error  out  1  load rejected
words_loaded  out  ADDR_WIDTH  count of words accepted in the current load

Behaviour:
- Reset (async): state=IDLE; cpu_reset=1; mem_we=0; mem_addr=0; mem_wdata=0; s_ready=0; busy=0; done=0; error=0; words_loaded=0; checksum=0.
- States:
  - IDLE: cpu_reset=1, s_ready=0.
  - LOAD: s_ready=1, busy=1, cpu_reset=1.
  - CHECK: one cycle, busy=1, s_ready=0.
  - RUN: cpu_reset=0, done=1.
  - ERROR: error=1, cpu_reset=1.
- start in IDLE, RUN or ERROR:
  - Captures base_addr, word_count and expected_sum; clears words_loaded, the checksum, done and error.
  - word_count==0 -> ERROR.
  - Otherwise -> LOAD.
  - From RUN, cpu_reset reasserts on the same edge that leaves RUN.
- start in LOAD or CHECK: ignored.
- Handshake: a beat transfers on a rising edge with s_valid=1 and s_ready=1. s_ready is a decoded function of state only; it does not depend on s_valid.
- Write latency: 1 cycle.
  - The edge after beat k (k from 0): mem_we=1, mem_addr=base_addr+k mod 2^ADDR_WIDTH, mem_wdata=s_data of beat k.
  - mem_we=0 on any cycle without a preceding beat.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Address wrap: base_addr+k wraps modulo 2^ADDR_WIDTH with no flag.
- Checksum: sum of all accepted words, modulo 2^INSTR_WIDTH. words_loaded increments on each beat.
- LOAD -> CHECK on the edge that accepts beat word_count-1. s_ready=0 from the next cycle. The final mem_we pulse occurs in the CHECK cycle.
- s_valid low in LOAD: the loader stalls indefinitely; no timeout.
- CHECK -> RUN when CHECK_EN==0 or checksum==expected_sum. Otherwise -> ERROR. cpu_reset deasserts on the edge entering RUN.
- RUN and ERROR persist until start or reset.
- reset mid-LOAD: immediate return to the reset values above; partially written memory is not cleared.

Test Plan:
- Basic load: base_addr=0, word_count=4, words 0x1111/0x2222/0x3333/0x4444 on consecutive cycles, expected_sum=0xAAAA -> mem_we pulses at addr 0..3, each 1 cycle after its beat, with matching data; busy high throughout; done=1 and cpu_reset=0 two cycles after the last beat.
- Backpressure/gaps: word_count=3 with s_valid toggling 1,0,0,1,0,1 -> exactly 3 writes at consecutive addresses; no write on gap cycles; words_loaded=3.
- Checksum fail: words 0x0001, 0x0002 with expected_sum=0x0004 -> error=1, cpu_reset=1, done=0. Repeat with CHECK_EN=0 -> done=1.
- Wrap: base_addr=0xFFFE, word_count=4 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; checksum wraps modulo 2^16.
- Edge commands: start with word_count=0 -> ERROR the next cycle. start pulse during LOAD -> no effect on address sequence or count.
- Reload/reset: a start in RUN -> cpu_reset=1 the next cycle and a new load from the new base_addr. An async reset asserted mid-LOAD -> all outputs return to reset values without waiting for a clock edge.
